demux8_nbit_sync: RTL and testbench
===================================

Name: demux8_nbit_sync

Overview:
- Registered 1-to-8 demultiplexer, the return path of the 8:1 bus-select mux.
- Routes one N-bit word from a shared upstream source to one of eight downstream channels (e.g. per-bus CAN/elink lanes) selected by sel.
- Each channel has its own valid/ready handshake.
- A stuck channel is timed out so the shared source never deadlocks.

Parameters:
- WIDTH, 2, data word width in bits.
- TIMEOUT, 255, max cycles a word waits in a channel register before being dropped; 8-bit counter, legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  word from upstream.
- sel  input  3  destination channel index, sampled with data_in.
- valid_in  input  1  upstream word valid.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- valid_out  output  8  per-channel word valid.
- ready_in  input  8  per-channel sink ready.
- timeout_err  output  1  single-cycle pulse when a word is dropped.
- err_chan  output  3  channel of the last dropped word; held until the next drop.

Behaviour:
- Reset (rst=0, async): state IDLE, data_out=0, valid_out=0, ready_out=0, timeout_err=0, err_chan=0, wait counter=0. The first cycle after release is IDLE with ready_out=1.
- Accept: valid_in & ready_out on a rising edge.
- FSM states: IDLE, HOLD.
- IDLE:
  - ready_out=1.
  - On accept: data_in is latched into channel sel's data slice, valid_out[sel] is set, sel is latched as the active channel, counter is cleared, and the state goes to HOLD.
  - Latency from accept to valid_out is 1 cycle.
- HOLD:
  - ready_out=0, combinationally.
  - Only the active channel's valid_out bit is 1.
  - On ready_in[active]=1 (transfer): valid_out[active] clears on the next edge and the state returns to IDLE.
  - The data slice keeps its last value; it is not cleared.
  - Otherwise the counter increments.
  - When the counter equals TIMEOUT-1 and there is no transfer this cycle: valid_out[active] clears, timeout_err pulses for 1 cycle, err_chan takes the active channel, and the state returns to IDLE.
- Transfer and timeout in the same cycle: transfer wins, with no error pulse.
- Throughput: at most one word per 2 cycles (accept, then transfer). No back-to-back acceptance; this is accepted by design.
- ready_in of non-active channels is ignored. valid_out is one-hot or zero at all times.
- sel and data_in are ignored when not accepted. Any 3-bit sel is legal, so no default/error path is needed.
- Counter is 8 bits wide and never wraps, because the exit occurs at TIMEOUT-1.
- Reset mid-HOLD: the pending word is lost silently and all outputs return to their reset values, with no timeout_err.
- All outputs except ready_out are registered. ready_out is decoded from the state only, with no combinational path from valid_in or ready_in.

Decomposition:
- Shared package (mopshub-wide): channel count 8, channel index width 3, and the FSM state encoding (IDLE=1'b0, HOLD=1'b1).
- One sub-module is natural: wait_timer, an 8-bit up-counter with clear, enable and a terminal flag at TIMEOUT-1, reusable by other bus-timeout logic.
- Channel registers are a generate loop and need no sub-module.

Test Plan:
- Reset release, ready_in=8'hFF, valid_in=1, sel=5, data_in=2'b10 -> next cycle valid_out=8'b0010_0000, data_out[11:10]=2'b10, ready_out=0; the following cycle valid_out=0, ready_out=1.
- Sweep sel 0..7 with data_in=sel[1:0] and ready_in=8'hFF -> each word appears only on its channel. Accepts occur every 2 cycles and no other valid_out bit ever rises.
- Backpressure: sel=3, ready_in=0 for 10 cycles, then ready_in[3]=1 -> valid_out[3] is held 11 cycles, ready_out=0 throughout, one transfer, no timeout_err.
- Timeout: TIMEOUT=4, sel=6, ready_in=0 -> timeout_err pulses exactly 4 cycles after valid_out[6] rises, err_chan=6, valid_out=0, ready_out=1 the next cycle.
- Race: TIMEOUT=4, ready_in[6] asserted in the terminal cycle -> normal transfer, timeout_err stays 0.
- Async reset asserted mid-HOLD (between edges) -> valid_out, data_out, ready_out and timeout_err go to 0 immediately without a clock edge. After release the block accepts a new word normally.

Source files
------------

// File: rtl/demux8_nbit_sync_pkg.sv
// Shared definitions for the 8-channel bus-select return path.
// The channel count, the index width and the demux FSM encoding live here.
package demux8_nbit_sync_pkg;

    localparam int unsigned NUM_CHAN = 8;
    localparam int unsigned CHAN_W   = 3;

    typedef logic [CHAN_W-1:0] chan_t;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

endpackage

// File: rtl/demux8_nbit_sync_wait_timer.sv
// 8-bit wait counter with synchronous clear and enable.
// terminal flags the last permitted wait cycle (count == TIMEOUT-1).
module demux8_nbit_sync_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign terminal = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/demux8_nbit_sync.sv
// Registered 1-to-8 demultiplexer with per-channel valid/ready.
// A word that is not taken within TIMEOUT cycles is dropped and flagged.
module demux8_nbit_sync
    import demux8_nbit_sync_pkg::*;
#(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          data_in,
    input  logic [CHAN_W-1:0]         sel,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic [NUM_CHAN*WIDTH-1:0] data_out,
    output logic [NUM_CHAN-1:0]       valid_out,
    input  logic [NUM_CHAN-1:0]       ready_in,
    output logic                      timeout_err,
    output logic [CHAN_W-1:0]         err_chan
);

    state_e              state_q;
    chan_t               active_q;
    logic [NUM_CHAN-1:0] valid_q;
    logic                terr_q;
    chan_t               err_chan_q;
    logic [WIDTH-1:0]    chan_data_q [NUM_CHAN];

    logic accept;
    logic transfer;
    logic terminal;

    assign accept   = valid_in && (state_q == StIdle);
    assign transfer = (state_q == StHold) && ready_in[active_q];

    // Counting stops at the terminal value, so the 8-bit counter never wraps.
    demux8_nbit_sync_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       ((state_q == StHold) && !transfer && !terminal),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            active_q   <= '0;
            valid_q    <= '0;
            terr_q     <= 1'b0;
            err_chan_q <= '0;
        end else begin
            terr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        state_q  <= StHold;
                        active_q <= sel;
                        valid_q  <= NUM_CHAN'(1) << sel;
                    end
                end
                StHold: begin
                    // A transfer in the terminal cycle takes priority over the drop.
                    if (ready_in[active_q]) begin
                        state_q <= StIdle;
                        valid_q <= '0;
                    end else if (terminal) begin
                        state_q    <= StIdle;
                        valid_q    <= '0;
                        terr_q     <= 1'b1;
                        err_chan_q <= active_q;
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                chan_data_q[k] <= '0;
            end else if (accept && (sel == chan_t'(k))) begin
                chan_data_q[k] <= data_in;
            end
        end
        assign data_out[k*WIDTH +: WIDTH] = chan_data_q[k];
    end

    // Held low while reset is asserted; otherwise a pure decode of the state.
    assign ready_out   = rst && (state_q == StIdle);
    assign valid_out   = valid_q;
    assign timeout_err = terr_q;
    assign err_chan    = err_chan_q;

endmodule

// File: tb/tb_demux8_nbit_sync.sv
// Self-checking bench: two instances (TIMEOUT=4 and 255) share stimulus and
// are compared every cycle against a pending-word model, plus directed checks.
module tb_demux8_nbit_sync;

    localparam int W    = 2;
    localparam int TO_A = 4;
    localparam int TO_B = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_in;
    logic [2:0]    sel;
    logic          valid_in;
    logic [7:0]    ready_in;

    logic          rdy_a, rdy_b, terr_a, terr_b;
    logic [8*W-1:0] dout_a, dout_b;
    logic [7:0]    vout_a, vout_b;
    logic [2:0]    ech_a, ech_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux8_nbit_sync #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .valid_in(valid_in),
        .ready_out(rdy_a), .data_out(dout_a), .valid_out(vout_a), .ready_in(ready_in),
        .timeout_err(terr_a), .err_chan(ech_a)
    );

    demux8_nbit_sync #(.WIDTH(W), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .valid_in(valid_in),
        .ready_out(rdy_b), .data_out(dout_b), .valid_out(vout_b), .ready_in(ready_in),
        .timeout_err(terr_b), .err_chan(ech_b)
    );

    // Model: each instance either holds one pending word (channel, age) or is empty.
    logic         m_hold  [2];
    logic [2:0]   m_ch    [2];
    int           m_age   [2];
    logic         m_err   [2];
    logic [2:0]   m_errch [2];
    logic [W-1:0] m_data  [2][8];

    function automatic int limit(input int i);
        return (i == 0) ? TO_A : TO_B;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_hold[i]  <= 1'b0;
                m_ch[i]    <= 3'd0;
                m_age[i]   <= 0;
                m_err[i]   <= 1'b0;
                m_errch[i] <= 3'd0;
                for (int k = 0; k < 8; k++) m_data[i][k] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_err[i] <= 1'b0;
                if (!m_hold[i]) begin
                    if (valid_in) begin
                        m_hold[i]         <= 1'b1;
                        m_ch[i]           <= sel;
                        m_age[i]          <= 0;
                        m_data[i][sel]    <= data_in;
                    end
                end else if (ready_in[m_ch[i]]) begin
                    m_hold[i] <= 1'b0;
                end else if (m_age[i] + 1 == limit(i)) begin
                    m_hold[i]  <= 1'b0;
                    m_err[i]   <= 1'b1;
                    m_errch[i] <= m_ch[i];
                end else begin
                    m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string p, input int i, input logic r, input logic [7:0] v,
                              input logic [8*W-1:0] d, input logic t, input logic [2:0] e);
        logic [7:0]     ev;
        logic [8*W-1:0] ed;
        ev = m_hold[i] ? (8'd1 << m_ch[i]) : 8'd0;
        for (int k = 0; k < 8; k++) ed[k*W +: W] = m_data[i][k];
        check({p, ".ready_out"},   32'(r), 32'(rst && !m_hold[i]));
        check({p, ".valid_out"},   32'(v), 32'(ev));
        check({p, ".data_out"},    32'(d), 32'(ed));
        check({p, ".timeout_err"}, 32'(t), 32'(m_err[i]));
        check({p, ".err_chan"},    32'(e), 32'(m_errch[i]));
    endtask

    task automatic check_all();
        check_inst("a", 0, rdy_a, vout_a, dout_a, terr_a, ech_a);
        check_inst("b", 1, rdy_b, vout_b, dout_b, terr_b, ech_b);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        valid_in = 1'b0;
        ready_in = 8'hFF;
        step();
        step();
    endtask

    int cyc, hi_cnt, rdy_cnt, terr_cnt;
    logic seen;

    initial begin
        rst      = 1'b0;
        data_in  = '0;
        sel      = '0;
        valid_in = 1'b0;
        ready_in = '0;
        @(negedge clk);
        check("rst.valid_out", 32'(vout_b), 32'h0);
        check("rst.ready_out", 32'(rdy_b), 32'h0);
        check("rst.data_out",  32'(dout_b), 32'h0);
        check_all();

        // Basic accept on channel 5, then transfer.
        rst      = 1'b1;
        ready_in = 8'hFF;
        valid_in = 1'b1;
        sel      = 3'd5;
        data_in  = 2'b10;
        step();
        valid_in = 1'b0;
        check("t1.valid_out", 32'(vout_b), 32'h20);
        check("t1.data_slice", 32'(dout_b[11:10]), 32'h2);
        check("t1.ready_out", 32'(rdy_b), 32'h0);
        step();
        check("t1.valid_clr", 32'(vout_b), 32'h0);
        check("t1.ready_back", 32'(rdy_b), 32'h1);

        // Sweep all channels with continuous valid_in.
        valid_in = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel     = 3'(s);
            data_in = 2'(s);
            step();
            step();
        end
        drain();

        // Timeout on the TIMEOUT=4 instance.
        ready_in = 8'h00;
        valid_in = 1'b1;
        sel      = 3'd6;
        data_in  = 2'b01;
        step();
        valid_in = 1'b0;
        check("to.valid_rise", 32'(vout_a), 32'h40);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            step();
            if (terr_a) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        check("to.pulse_seen", 32'(seen), 32'h1);
        check("to.latency", 32'(cyc), 32'd4);
        check("to.err_chan", 32'(ech_a), 32'd6);
        check("to.valid_out", 32'(vout_a), 32'h0);
        check("to.ready_out", 32'(rdy_a), 32'h1);
        step();
        check("to.single_pulse", 32'(terr_a), 32'h0);
        drain();

        // Transfer in the terminal cycle beats the timeout.
        ready_in = 8'h00;
        valid_in = 1'b1;
        sel      = 3'd6;
        data_in  = 2'b10;
        step();
        valid_in = 1'b0;
        step();
        step();
        step();
        ready_in = 8'h40;
        step();
        check("race.no_err", 32'(terr_a), 32'h0);
        check("race.valid_out", 32'(vout_a), 32'h0);
        check("race.ready_out", 32'(rdy_a), 32'h1);
        step();
        check("race.no_err_late", 32'(terr_a), 32'h0);
        drain();

        // Backpressure on the TIMEOUT=255 instance.
        ready_in = 8'h00;
        valid_in = 1'b1;
        sel      = 3'd3;
        data_in  = 2'b11;
        hi_cnt   = 0;
        rdy_cnt  = 0;
        terr_cnt = 0;
        step();
        valid_in = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (vout_b[3]) hi_cnt++;
            if (rdy_b) rdy_cnt++;
            if (terr_b) terr_cnt++;
            if (c == 10) ready_in = 8'h08;
            step();
        end
        check("bp.hold_cycles", 32'(hi_cnt), 32'd11);
        check("bp.ready_low", 32'(rdy_cnt), 32'd0);
        check("bp.no_err", 32'(terr_cnt + 32'(terr_b)), 32'd0);
        check("bp.released", 32'(vout_b), 32'h0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            sel      = 3'($urandom);
            data_in  = 2'($urandom);
            for (int k = 0; k < 8; k++) ready_in[k] = ($urandom_range(0, 9) < 3);
            step();
        end
        drain();

        // Asynchronous reset in the middle of HOLD.
        ready_in = 8'h00;
        valid_in = 1'b1;
        sel      = 3'd2;
        data_in  = 2'b11;
        step();
        valid_in = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("ar.valid_a", 32'(vout_a), 32'h0);
        check("ar.valid_b", 32'(vout_b), 32'h0);
        check("ar.data_b", 32'(dout_b), 32'h0);
        check("ar.ready_b", 32'(rdy_b), 32'h0);
        check("ar.terr_b", 32'(terr_b), 32'h0);
        check_all();
        @(negedge clk);
        check_all();
        rst      = 1'b1;
        ready_in = 8'hFF;
        valid_in = 1'b1;
        sel      = 3'd1;
        data_in  = 2'b10;
        step();
        valid_in = 1'b0;
        check("ar.reaccept_valid", 32'(vout_b), 32'h02);
        check("ar.reaccept_data", 32'(dout_b[3:2]), 32'h2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
